// File: rtl/frame_buffer.sv
// frame_buffer: double-buffered colour frame store between the rasterizer and the DVI output FIFO
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   rast_pixel_rdy              rasterizer pixel valid
//   rast_color_input            pixel colour
//   rast_width / rast_height    pixel x / y coordinate
//   rast_done                   rasterizer finished current frame
//   next_frame_switch           clipping requests a buffer swap (with rast_done)
//   read_rast_pixel_rdy         one-cycle registered ack after each accepted write
//   dvi_fifo_full               DVI FIFO back-pressure
//   dvi_color_out               pixel colour to the DVI FIFO
//   dvi_fifo_write_enable       push dvi_color_out into the DVI FIFO
// Config: define CLEAR_ON_SWAP_EN to zero the new back bank (one word/cycle) after every swap.
module frame_buffer #(
  parameter int H_PIX   = 640,
  parameter int V_PIX   = 480,
  parameter int COLOR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rast_pixel_rdy,
  input  logic [COLOR_W-1:0] rast_color_input,
  input  logic [9:0]         rast_width,
  input  logic [8:0]         rast_height,
  input  logic               rast_done,
  input  logic               next_frame_switch,
  output logic               read_rast_pixel_rdy,
  input  logic               dvi_fifo_full,
  output logic [COLOR_W-1:0] dvi_color_out,
  output logic               dvi_fifo_write_enable
);
  localparam int N = H_PIX * V_PIX;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [COLOR_W-1:0] mem0 [N];
  logic [COLOR_W-1:0] mem1 [N];
  logic [COLOR_W-1:0] rd_q;
  logic front_q, front_d, pend_q, pend_d, out_v_q, out_v_d, ack_q, ack_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic in_range, accept, advance, swap, clearing, wr_en;
  logic [AW-1:0] pix_addr, wr_addr;
  logic [COLOR_W-1:0] wr_data;

  assign in_range = int'(rast_width) < H_PIX && int'(rast_height) < V_PIX;
  assign pix_addr = AW'(int'(rast_height) * H_PIX + int'(rast_width));

  // A swap is taken either at the frame wrap (last address being read) or,
  // if the reader is stalled at address 0, before the first read of the frame.
  always_comb begin
    advance = ~out_v_q | ~dvi_fifo_full;
    swap = pend_q & ~clearing & (advance ? rd_addr_q == LAST : rd_addr_q == '0);
    accept = rast_pixel_rdy & in_range & ~clearing;
    front_d = swap ? ~front_q : front_q;
    pend_d = ~swap & (pend_q | (next_frame_switch & rast_done));
    rd_addr_d = !advance ? rd_addr_q : rd_addr_q == LAST ? '0 : rd_addr_q + AW'(1);
    out_v_d = out_v_q | advance;
    ack_d = accept;
  end

`ifdef CLEAR_ON_SWAP_EN
  logic clr_q, clr_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  assign clearing = clr_q;
  assign wr_en = clr_q | accept;
  assign wr_addr = clr_q ? clr_addr_q : pix_addr;
  assign wr_data = clr_q ? '0 : rast_color_input;

  always_comb begin
    clr_d = swap | (clr_q & (clr_addr_q != LAST));
    clr_addr_d = swap ? '0 : clr_q ? clr_addr_q + AW'(1) : clr_addr_q;
  end

  always_ff @(posedge clk)
    if (rst) begin
      clr_q <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      clr_q <= clr_d;
      clr_addr_q <= clr_addr_d;
    end
`else
  assign clearing = 1'b0;
  assign wr_en = accept;
  assign wr_addr = pix_addr;
  assign wr_data = rast_color_input;
`endif

  always_ff @(posedge clk)
    if (rst) begin
      front_q <= 1'b0;
      pend_q <= 1'b0;
      out_v_q <= 1'b0;
      ack_q <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      front_q <= front_d;
      pend_q <= pend_d;
      out_v_q <= out_v_d;
      ack_q <= ack_d;
      rd_addr_q <= rd_addr_d;
    end

  // Writes always target the back bank (~front), reads the front bank, so the
  // two ports never collide; rd_q doubles as the output data register.
  always_ff @(posedge clk) begin
    if (wr_en && front_q) mem0[wr_addr] <= wr_data;
    if (wr_en && !front_q) mem1[wr_addr] <= wr_data;
    if (advance) rd_q <= front_q ? mem1[rd_addr_q] : mem0[rd_addr_q];
  end

  assign read_rast_pixel_rdy = ack_q;
  assign dvi_color_out = out_v_q ? rd_q : '0;
  assign dvi_fifo_write_enable = out_v_q & ~dvi_fifo_full;
endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: self-checking bench for frame_buffer against a frame-level reference model
module tb_frame_buffer;
  localparam int H = 16;
  localparam int V = 8;
  localparam int N = H * V;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b0, done = 1'b0, sw = 1'b0, full = 1'b0;
  logic [2:0] col = '0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic ack, we;
  logic [2:0] dout;

  frame_buffer #(.H_PIX(H), .V_PIX(V), .COLOR_W(3)) dut (
    .clk(clk), .rst(rst), .rast_pixel_rdy(rdy), .rast_color_input(col),
    .rast_width(x), .rast_height(y), .rast_done(done), .next_frame_switch(sw),
    .read_rast_pixel_rdy(ack), .dvi_fifo_full(full), .dvi_color_out(dout),
    .dvi_fifo_write_enable(we)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int mb [2][N];
  int oq [$];
  int m_front, m_pend, m_ra, m_clr, m_ack;

  typedef struct { int x; int y; int c; int ack; } vec_t;
  vec_t tbl [8];

  task automatic check(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_front = 0; m_pend = 0; m_ra = 0; m_clr = 0; m_ack = 0;
    oq.delete();
  endtask

  task automatic check_outputs();
    bit exp_we;
    exp_we = oq.size() > 0 && !full;
    check("ack", int'(ack), m_ack);
    check("write_enable", int'(we), int'(exp_we));
    if (exp_we && oq[0] >= 0) check("pixel", int'(dout), oq[0]);
  endtask

  // One clock of the frame-level model: output register drains when the FIFO is not full,
  // a read of the front frame issues whenever the register is empty or draining,
  // and a pending swap is taken at the frame wrap or while stalled at address 0.
  task automatic model_step();
    bit emit, fetch, acc, swp;
    emit = oq.size() > 0 && !full;
    fetch = oq.size() == 0 || !full;
    acc = rdy && int'(x) < H && int'(y) < V && m_clr == 0;
    swp = m_pend && m_clr == 0 && (fetch ? m_ra == N - 1 : m_ra == 0);
    if (m_clr > 0) m_clr--;
    if (acc) mb[1 - m_front][int'(y) * H + int'(x)] = int'(col);
    m_ack = acc;
    if (emit) void'(oq.pop_front());
    if (fetch) begin
      oq.push_back(mb[m_front][m_ra]);
      m_ra = (m_ra + 1) % N;
    end
    if (swp) begin
      m_front = 1 - m_front;
      m_pend = 0;
`ifdef CLEAR_ON_SWAP_EN
      m_clr = N;
      for (int i = 0; i < N; i++) mb[1 - m_front][i] = 0;
`endif
    end else if (sw && done) m_pend = 1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b0; done = 1'b0; sw = 1'b0; full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst_ack", int'(ack), 0);
    check("rst_we", int'(we), 0);
    check("rst_dout", int'(dout), 0);
  endtask

  task automatic wait_ra(int target);
    for (int i = 0; i < 4 * N && m_ra != target; i++) cycle();
    if (m_ra != target) begin
      nerr++;
      $display("FAIL wait_ra: read address %0d never reached %0d", m_ra, target);
    end
  endtask

  task automatic swap_req();
    done = 1'b1; sw = 1'b1;
    cycle();
    done = 1'b0; sw = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) mb[b][i] = -1;
    // x/y/colour/expected-ack; out-of-range x=H aliases (0,1) in the linear address space
    tbl[0] = '{16, 0, 5, 0};
    tbl[1] = '{0, 8, 5, 0};
    tbl[2] = '{640, 0, 6, 0};
    tbl[3] = '{1023, 511, 2, 0};
    tbl[4] = '{15, 7, 6, 1};
    tbl[5] = '{0, 0, 7, 1};
    tbl[6] = '{16, 7, 3, 0};
    tbl[7] = '{3, 480, 4, 0};

    do_reset();
    // Fill the back bank (bank 1) with the reference pattern.
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) begin
        rdy = 1'b1; x = 10'(xx); y = 9'(yy); col = 3'((yy * H + xx + 1) % 8);
        cycle();
      end
    rdy = 1'b0;
    cycle();
    // Boundary writes from the table.
    for (int i = 0; i < 8; i++) begin
      rdy = 1'b1; x = 10'(tbl[i].x); y = 9'(tbl[i].y); col = 3'(tbl[i].c);
      cycle();
      rdy = 1'b0;
      check("tbl_ack", int'(ack), tbl[i].ack);
    end
    // Swap and display two frames: the pattern must stream from bank 1.
    swap_req();
    repeat (2 * N + 4) cycle();
    check("front_after_swap", m_front, 1);
    // Back-pressure mid-line for 10 cycles.
    wait_ra(2 * H + 5);
    full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_we_low", int'(we), 0);
    end
    full = 1'b0;
    repeat (2 * H) cycle();
    // Fill bank 0 with a shifted pattern while bank 1 streams, then swap mid-frame.
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) begin
        rdy = 1'b1; x = 10'(xx); y = 9'(yy); col = 3'((yy * H + xx + 5) % 8);
        cycle();
      end
    rdy = 1'b0;
`ifdef CLEAR_ON_SWAP_EN
    repeat (N) cycle();
`endif
    wait_ra(N / 2);
    swap_req();
    repeat (3) cycle();
    swap_req();
    repeat (3 * N) cycle();
    // Randomized traffic with back-pressure and swap requests.
    for (int i = 0; i < 3000; i++) begin
      rdy = 1'($urandom_range(0, 1));
      x = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, H - 1));
      y = ($urandom_range(0, 5) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, V - 1));
      col = 3'($urandom);
      full = (i % 700 > 600) ? 1'($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 3) == 0);
      done = 1'($urandom_range(0, 9) == 0);
      sw = 1'($urandom_range(0, 9) == 0);
      cycle();
    end
    done = 1'b0; sw = 1'b0; rdy = 1'b0; full = 1'b0;
    repeat (8) cycle();
    // Reset mid-operation: first word must again be bank 0 address 0.
    do_reset();
    repeat (2 * N) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
